// File: rtl/bcd_conversion_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.
// Define BCD_CONVERSION_CTRL_SIGNED_EN to treat in_data as two's complement (magnitude + sign_out).
module bcd_conversion_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic                  busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    // Decimal digit count of 2^WIDTH-1, using log10(2) ~= 0.30103.
    localparam int MIN_DIGITS = (WIDTH * 30103) / 100000 + 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("bcd_conversion_ctrl: WIDTH must be >= 2");
    end
    if (DIGITS < MIN_DIGITS) begin : g_bad_digits
        $error("bcd_conversion_ctrl: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      count;
    logic [WIDTH-1:0]      shift_reg;
    logic [4*DIGITS-1:0]   digits;
    logic [4*DIGITS-1:0]   digits_adj;
    logic [4*DIGITS-1:0]   digits_nxt;
    logic [WIDTH-1:0]      shift_nxt;
    logic [WIDTH-1:0]      in_mag;

    function automatic logic [4*DIGITS-1:0] adjust_digits(input logic [4*DIGITS-1:0] d);
        logic [4*DIGITS-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef BCD_CONVERSION_CTRL_SIGNED_EN
    logic signed [WIDTH-1:0] in_signed;
    logic                    sign_reg;
    logic                    sign_q;

    assign in_signed = in_data;
    // Negation stays WIDTH bits: the most negative value maps to its own unsigned pattern.
    assign in_mag    = in_signed[WIDTH-1] ? $unsigned(-in_signed) : in_data;
    assign sign_out  = sign_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sign_q <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                sign_reg <= in_data[WIDTH-1];
            end
            if (state == SHIFT && count == '0) begin
                sign_q <= sign_reg;
            end
        end
    end
`else
    assign in_mag   = in_data;
    assign sign_out = 1'b0;
`endif

    // One double-dabble iteration: add-3 correction, then shift the binary MSB into the units digit.
    always_comb begin
        digits_adj = adjust_digits(digits);
        digits_nxt = {digits_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
        shift_nxt  = {shift_reg[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_mag;
                        digits    <= '0;
                        count     <= CNT_W'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    digits    <= digits_nxt;
                    shift_reg <= shift_nxt;
                    if (count == '0) begin
                        bcd_out <= digits_nxt;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conversion_ctrl.sv
// Directed bench for bcd_conversion_ctrl: an 8-bit/3-digit instance and a 16-bit/5-digit instance.
module tb_bcd_conversion_ctrl;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd_out;
    logic        sign_out;
    logic        busy;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] in_data16;
    logic        out_valid16;
    logic        out_ready16;
    logic [19:0] bcd_out16;
    logic        sign_out16;
    logic        busy16;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BCD_CONVERSION_CTRL_SIGNED_EN
    localparam logic [11:0] EXP_FF   = 12'h001;
    localparam logic [19:0] EXP_FFFF = 20'h00001;
    localparam logic        SIGNED_B = 1'b1;
`else
    localparam logic [11:0] EXP_FF   = 12'h255;
    localparam logic [19:0] EXP_FFFF = 20'h65535;
    localparam logic        SIGNED_B = 1'b0;
`endif

    bcd_conversion_ctrl #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .sign_out  (sign_out),
        .busy      (busy)
    );

    bcd_conversion_ctrl #(.WIDTH(16), .DIGITS(5)) u_dut16 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .bcd_out   (bcd_out16),
        .sign_out  (sign_out16),
        .busy      (busy16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept val at the next edge, then check SHIFT timing and the result on the first DONE cycle.
    task automatic run8(input logic [7:0] val, input logic [11:0] exp_bcd, input string tag);
        logic exp_sign;
        exp_sign = SIGNED_B & val[7];
        in_data  = val;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hA5;
        chk({tag, ":busy_c1"}, 32'(busy), 32'd1);
        chk({tag, ":in_ready_c1"}, 32'(in_ready), 32'd0);
        repeat (7) tick();
        chk({tag, ":busy_c8"}, 32'(busy), 32'd1);
        chk({tag, ":out_valid_c8"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, ":out_valid_c9"}, 32'(out_valid), 32'd1);
        chk({tag, ":busy_c9"}, 32'(busy), 32'd0);
        chk({tag, ":bcd"}, 32'(bcd_out), 32'(exp_bcd));
        chk({tag, ":sign"}, 32'(sign_out), 32'(exp_sign));
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        out_ready   = 1'b1;
        in_valid16  = 1'b0;
        in_data16   = 16'd0;
        out_ready16 = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk("rst:in_ready", 32'(in_ready), 32'd1);
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:bcd", 32'(bcd_out), 32'd0);
        chk("rst:sign", 32'(sign_out), 32'd0);
        chk("rst16:in_ready", 32'(in_ready16), 32'd1);

        // Full-scale input, consumer always ready.
        run8(8'd255, EXP_FF, "t1");
        tick();
        chk("t1:in_ready_c10", 32'(in_ready), 32'd1);
        chk("t1:out_valid_c10", 32'(out_valid), 32'd0);

        run8(8'd0, 12'h000, "t2a");
        tick();
        run8(8'd9, 12'h009, "t2b");
        tick();
        run8(8'd100, 12'h100, "t2c");
        tick();
        run8(8'h7F, 12'h127, "t2d");
        tick();

        // Back-pressure: result must hold and new requests must be ignored.
        out_ready = 1'b0;
        run8(8'd99, 12'h099, "t3");
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd5;
            tick();
            chk("t3:hold_valid", 32'(out_valid), 32'd1);
            chk("t3:hold_in_ready", 32'(in_ready), 32'd0);
            chk("t3:hold_bcd", 32'(bcd_out), 32'h099);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3:idle_in_ready", 32'(in_ready), 32'd1);
        chk("t3:idle_out_valid", 32'(out_valid), 32'd0);
        chk("t3:bcd_kept", 32'(bcd_out), 32'h099);
        tick();
        chk("t3:no_stray_busy", 32'(busy), 32'd0);

        // Reset on the fourth SHIFT cycle aborts the conversion.
        in_data  = 8'd200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t4:busy_before_rst", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4:out_valid", 32'(out_valid), 32'd0);
        chk("t4:bcd", 32'(bcd_out), 32'd0);
        chk("t4:in_ready", 32'(in_ready), 32'd1);
        chk("t4:busy", 32'(busy), 32'd0);
        run8(8'd128, 12'h128, "t4b");
        tick();

        // Wide instance: 16 SHIFT cycles, out_valid at cycle 17.
        in_data16  = 16'hFFFF;
        in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        in_data16  = 16'h1234;
        chk("t6:busy_c1", 32'(busy16), 32'd1);
        repeat (15) tick();
        chk("t6:busy_c16", 32'(busy16), 32'd1);
        chk("t6:out_valid_c16", 32'(out_valid16), 32'd0);
        tick();
        chk("t6:out_valid_c17", 32'(out_valid16), 32'd1);
        chk("t6:bcd", 32'(bcd_out16), 32'(EXP_FFFF));
        chk("t6:sign", 32'(sign_out16), 32'(SIGNED_B));
        tick();
        chk("t6:in_ready_c18", 32'(in_ready16), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
